dispense_ctrl: RTL

Transaction sequencer for the ATM note dispenser. It accepts a withdrawal request for N notes and validates it against the account balance, the notes in the machine and, optionally, a daily limit. It then issues N single-cycle `count_down` pulses to the dispenser, spaced by a fixed gap, and ends the transaction with a one-cycle `done` or `err`. It sits between the menu/keypad logic and the per-note withdraw pulse path, and owns the balance and cash-in-machine registers.

---
 rtl/dispense_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dispense_ctrl.sv
// dispense_ctrl -- ATM note-dispense transaction sequencer.
//
// Accepts a withdrawal request for N notes, validates it against the account
// balance, the notes in the machine and (optionally) a daily limit, then issues
// N single-cycle count_down pulses spaced by NOTE_GAP idle cycles and closes
// the transaction with a one-cycle done or err. Owns the balance and
// cash-in-machine registers.
//
// Optional feature macro: DAILY_LIMIT_EN
//   defined   -> spent-today counter, daily-limit check (err_code 2'b11),
//                day_rst clears the counter.
//   undefined -> no spent counter, code 2'b11 never produced, day_rst ignored.
//
// Ports:
//   clk         in   1      rising-edge clock
//   res         in   1      synchronous active-high reset
//   req         in   1      withdrawal request, sampled only in IDLE
//   amount      in   AMT_W  notes requested, sampled with req
//   refill_en   in   1      add refill_amt to cash_left (IDLE only)
//   refill_amt  in   BAL_W  notes loaded by the operator
//   day_rst     in   1      clear spent-today (DAILY_LIMIT_EN only)
//   busy        out  1      high in every state except IDLE
//   count_down  out  1      one-cycle pulse per dispensed note
//   done        out  1      one-cycle pulse on successful completion
//   err         out  1      one-cycle pulse on a rejected request
//   err_code    out  2      00 zero, 01 balance, 10 cash, 11 daily limit
//   balance     out  BAL_W  current account balance in notes
//   cash_left   out  BAL_W  notes remaining in the machine
module dispense_ctrl #(
  parameter int BAL_W       = 16,
  parameter int AMT_W       = 8,
  parameter int NOTE_GAP    = 4,
  parameter int INIT_BAL    = 1000,
  parameter int INIT_CASH   = 500,
  parameter int DAILY_LIMIT = 100
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill_en,
  input  logic [BAL_W-1:0] refill_amt,
  input  logic             day_rst,
  output logic             busy,
  output logic             count_down,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] cash_left
);

  // Compares run one bit wider than the counters so nothing can overflow.
  localparam int CMP_W = BAL_W + 1;
  localparam int GAP_W = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;

  localparam logic [BAL_W-1:0] BAL_INIT_C  = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] CASH_INIT_C = BAL_W'(INIT_CASH);
  localparam logic [BAL_W-1:0] BAL_ONE_C   = BAL_W'(1);
  localparam logic [BAL_W-1:0] BAL_ZERO_C  = BAL_W'(0);
  localparam logic [BAL_W-1:0] BAL_MAX_C   = {BAL_W{1'b1}};
  localparam logic [AMT_W-1:0] AMT_ONE_C   = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_ZERO_C  = AMT_W'(0);
  localparam logic [GAP_W-1:0] GAP_ZERO_C  = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE_C   = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD_C  = GAP_W'((NOTE_GAP > 0) ? (NOTE_GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_r;
  logic [AMT_W-1:0] remaining_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [BAL_W-1:0] balance_r;
  logic [BAL_W-1:0] cash_r;
  logic             busy_r;
  logic             count_down_r;
  logic             done_r;
  logic             err_r;
  logic [1:0]       err_code_r;

  logic [CMP_W-1:0] amt_ext_s;
  logic             chk_fail_s;
  logic [1:0]       chk_code_s;

`ifdef DAILY_LIMIT_EN
  localparam logic [CMP_W-1:0] LIMIT_C = CMP_W'(DAILY_LIMIT);
  logic [BAL_W-1:0] spent_r;
  logic [CMP_W-1:0] spent_sum_s;
`else
  // Without the daily limit, day_rst and DAILY_LIMIT have no function.
  logic unused_s;
  assign unused_s = day_rst ^ (DAILY_LIMIT > 0);
`endif

  // Saturating add used for refills and the spent-today counter.
  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    logic [CMP_W-1:0] sum;
    sum = CMP_W'(a) + CMP_W'(b);
    if (sum[BAL_W]) begin
      return BAL_MAX_C;
    end else begin
      return sum[BAL_W-1:0];
    end
  endfunction

  assign busy       = busy_r;
  assign count_down = count_down_r;
  assign done       = done_r;
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign balance    = balance_r;
  assign cash_left  = cash_r;

  // Request validation evaluated during CHECK; first failing rule wins.
  always_comb begin
    amt_ext_s  = CMP_W'(remaining_r);
    chk_fail_s = 1'b0;
    chk_code_s = 2'b00;
`ifdef DAILY_LIMIT_EN
    spent_sum_s = CMP_W'(spent_r) + amt_ext_s;
`endif
    if (remaining_r == AMT_ZERO_C) begin
      chk_fail_s = 1'b1;
      chk_code_s = 2'b00;
    end else if (amt_ext_s > CMP_W'(balance_r)) begin
      chk_fail_s = 1'b1;
      chk_code_s = 2'b01;
    end else if (amt_ext_s > CMP_W'(cash_r)) begin
      chk_fail_s = 1'b1;
      chk_code_s = 2'b10;
`ifdef DAILY_LIMIT_EN
    end else if (spent_sum_s > LIMIT_C) begin
      chk_fail_s = 1'b1;
      chk_code_s = 2'b11;
`endif
    end else begin
      chk_fail_s = 1'b0;
      chk_code_s = 2'b00;
    end
  end

  // Transaction FSM with registered Moore outputs set on entry to each state.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r      <= S_IDLE;
      remaining_r  <= AMT_ZERO_C;
      gap_cnt_r    <= GAP_ZERO_C;
      balance_r    <= BAL_INIT_C;
      cash_r       <= CASH_INIT_C;
      busy_r       <= 1'b0;
      count_down_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 2'b00;
    end else begin
      count_down_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // Refill lands on the same edge as the request, so CHECK sees it.
          if (refill_en) begin
            cash_r <= sat_add(cash_r, refill_amt);
          end
          if (req) begin
            remaining_r <= amount;
            state_r     <= S_CHECK;
            busy_r      <= 1'b1;
          end
        end
        S_CHECK: begin
          if (chk_fail_s) begin
            state_r    <= S_ERR;
            err_r      <= 1'b1;
            err_code_r <= chk_code_s;
          end else begin
            state_r      <= S_PULSE;
            count_down_r <= 1'b1;
          end
        end
        S_PULSE: begin
          // Validation guarantees these cannot underflow.
          balance_r   <= balance_r - BAL_ONE_C;
          cash_r      <= cash_r - BAL_ONE_C;
          remaining_r <= remaining_r - AMT_ONE_C;
          if (remaining_r == AMT_ONE_C) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else if (NOTE_GAP == 0) begin
            state_r      <= S_PULSE;
            count_down_r <= 1'b1;
          end else begin
            state_r   <= S_GAP;
            gap_cnt_r <= GAP_LOAD_C;
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_ZERO_C) begin
            state_r      <= S_PULSE;
            count_down_r <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_ONE_C;
          end
        end
        S_DONE, S_ERR: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAILY_LIMIT_EN
  // Spent-today counter; a day_rst coinciding with a pulse counts that note.
  always_ff @(posedge clk) begin
    if (res) begin
      spent_r <= BAL_ZERO_C;
    end else if (day_rst) begin
      spent_r <= (state_r == S_PULSE) ? BAL_ONE_C : BAL_ZERO_C;
    end else if (state_r == S_PULSE) begin
      spent_r <= sat_add(spent_r, BAL_ONE_C);
    end else begin
      spent_r <= spent_r;
    end
  end
`endif

endmodule
